// File: rtl/team_08_pkg.sv
// rtl/team_08_pkg.sv - shared game state type and width helpers for the dino runner
package team_08_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2,
        WIN  = 2'd3
    } state_t;

    localparam int SCORE_W = 7;

    // Width that holds 0..max_val; never narrower than one bit so zero-valued parameters still elaborate.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/team_08_game_controller_if.sv
// rtl/team_08_game_controller_if.sv - game controller input events and game status outputs
interface team_08_game_controller_if;
    import team_08_pkg::*;

    logic               button_in;
    logic               frame_tick;
    logic               collision_detect;
    state_t             state;
    logic               game_reset;
    logic               run_en;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    modport slave (
        input  button_in,
        input  frame_tick,
        input  collision_detect,
        output state,
        output game_reset,
        output run_en,
        output score,
        output high_score
    );

    modport master (
        output button_in,
        output frame_tick,
        output collision_detect,
        input  state,
        input  game_reset,
        input  run_en,
        input  score,
        input  high_score
    );

endinterface

// File: rtl/team_08_button_sync.sv
// rtl/team_08_button_sync.sv - button synchronizer with registered rising-edge pulse
module team_08_button_sync (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic btn_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_2_d  <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync_1    <= button_in;
            sync_2    <= sync_1;
            sync_2_d  <= sync_2;
            btn_pulse <= sync_2 & ~sync_2_d;
        end
    end

endmodule

// File: rtl/team_08_game_controller.sv
// rtl/team_08_game_controller.sv - dino runner game sequencer: state, scoring, grace and end-screen hold
module team_08_game_controller
    import team_08_pkg::*;
#(
    parameter int WIN_SCORE        = 99,
    parameter int SCORE_TICKS      = 30,
    parameter int GRACE_FRAMES     = 16,
    parameter int OVER_HOLD_FRAMES = 60
) (
    input  logic                       clk,
    input  logic                       reset,
    team_08_game_controller_if.slave   bus
);

    localparam int TICK_W  = cnt_w(SCORE_TICKS);
    localparam int GRACE_W = cnt_w(GRACE_FRAMES);
    localparam int HOLD_W  = cnt_w(OVER_HOLD_FRAMES);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SCORE_TICKS - 1);
    localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_FRAMES);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(OVER_HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic               btn_pulse;
    state_t             state_q;
    state_t             state_d;
    logic               game_reset_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] high_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic [GRACE_W-1:0] grace_cnt;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               tick_wrap;
    logic               collision_ok;
    logic               win_hit;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] final_score;

    team_08_button_sync u_button_sync (
        .clk       (clk),
        .reset     (reset),
        .button_in (bus.button_in),
        .btn_pulse (btn_pulse)
    );

    always_comb begin
        tick_wrap    = bus.frame_tick && (tick_cnt == TICK_LAST);
        score_inc    = score_q + SCORE_W'(1);
        final_score  = tick_wrap ? score_inc : score_q;
        // The game_reset cycle is masked so a dino spawned on a cactus cannot lose instantly.
        collision_ok = bus.collision_detect && (grace_cnt == '0) && !game_reset_q;
        win_hit      = tick_wrap && (score_inc == WIN_VAL);

        state_d = state_q;
        case (state_q)
            IDLE:      state_d = btn_pulse ? RUN : IDLE;
            RUN: begin
                if (collision_ok)  state_d = OVER;
                else if (win_hit)  state_d = WIN;
            end
            OVER, WIN: begin
                if (btn_pulse && (hold_cnt == '0)) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            game_reset_q <= 1'b0;
            score_q      <= '0;
            high_q       <= '0;
            tick_cnt     <= '0;
            grace_cnt    <= '0;
            hold_cnt     <= '0;
        end else begin
            state_q      <= state_d;
            game_reset_q <= (state_q != RUN) && (state_d == RUN);
            case (state_q)
                IDLE: begin
                    if (state_d == RUN) begin
                        score_q   <= '0;
                        tick_cnt  <= '0;
                        grace_cnt <= GRACE_INIT;
                    end
                end
                RUN: begin
                    if (bus.frame_tick) begin
                        if (grace_cnt != '0) grace_cnt <= grace_cnt - GRACE_W'(1);
                        tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                        if (tick_wrap) score_q <= score_inc;
                    end
                    if (state_d != RUN) begin
                        hold_cnt <= HOLD_INIT;
                        if (final_score > high_q) high_q <= final_score;
                    end
                end
                OVER, WIN: begin
                    if (bus.frame_tick && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.game_reset = game_reset_q;
    assign bus.run_en     = (state_q == RUN);
    assign bus.score      = score_q;
    assign bus.high_score = high_q;

endmodule

// File: tb/tb_team_08_game_controller.sv
// tb/tb_team_08_game_controller.sv - scoreboard bench for the dino runner game controller
module tb_team_08_game_controller;
    import team_08_pkg::*;

    localparam int ID_STATE = 0, ID_GR = 1, ID_RUN = 2, ID_SCORE = 3, ID_HIGH = 4, ID_GRCNT = 5;
    localparam int B = 8;

    typedef struct {
        int    cyc;
        int    id;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   gr_cnt_a = 0;
    int   gr_cnt_b = 0;
    exp_t sb[$];

    team_08_game_controller_if bus_a ();
    team_08_game_controller_if bus_b ();

    team_08_game_controller dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    team_08_game_controller #(
        .WIN_SCORE        (2),
        .SCORE_TICKS      (1),
        .GRACE_FRAMES     (0),
        .OVER_HOLD_FRAMES (0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input int id);
        case (id)
            ID_STATE:     return int'(bus_a.state);
            ID_GR:        return int'(bus_a.game_reset);
            ID_RUN:       return int'(bus_a.run_en);
            ID_SCORE:     return int'(bus_a.score);
            ID_HIGH:      return int'(bus_a.high_score);
            ID_GRCNT:     return gr_cnt_a;
            B + ID_STATE: return int'(bus_b.state);
            B + ID_GR:    return int'(bus_b.game_reset);
            B + ID_RUN:   return int'(bus_b.run_en);
            B + ID_SCORE: return int'(bus_b.score);
            B + ID_HIGH:  return int'(bus_b.high_score);
            B + ID_GRCNT: return gr_cnt_b;
            default:      return -1;
        endcase
    endfunction

    // Monitor: pops every expectation due by the current cycle and compares mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int   got;
        if (bus_a.game_reset === 1'b1) gr_cnt_a++;
        if (bus_b.game_reset === 1'b1) gr_cnt_b++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            got = sample(e.id);
            n_vec++;
            if (got != e.val) begin
                n_err++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, got, e.val, cyc);
            end
        end
    end

    task automatic chk(input int id, input int val, input string name);
        sb.push_back('{cyc, id, val, name});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.frame_tick = 1'b1;
            ticks(1);
            bus_a.frame_tick = 1'b0;
            ticks(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.button_in = 1'b0; bus_a.frame_tick = 1'b0; bus_a.collision_detect = 1'b0;
        bus_b.button_in = 1'b0; bus_b.frame_tick = 1'b0; bus_b.collision_detect = 1'b0;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        chk(ID_STATE, int'(IDLE), "reset_state");
        chk(ID_GR, 0, "reset_game_reset");
        chk(ID_RUN, 0, "reset_run_en");
        chk(ID_SCORE, 0, "reset_score");
        chk(ID_HIGH, 0, "reset_high_score");
        ticks(1);

        // Short-game instance: grace 0, win at 2, one tick per point, no end-screen hold.
        bus_b.button_in = 1'b1;
        ticks(4);
        chk(B + ID_STATE, int'(RUN), "b_start_run");
        chk(B + ID_GR, 1, "b_start_game_reset");
        bus_b.collision_detect = 1'b1;
        ticks(1);
        bus_b.collision_detect = 1'b0;
        chk(B + ID_STATE, int'(RUN), "b_collision_masked_by_game_reset");
        bus_b.button_in = 1'b0;
        bus_b.frame_tick = 1'b1;
        ticks(1);
        chk(B + ID_SCORE, 1, "b_score_1");
        bus_b.collision_detect = 1'b1;
        ticks(1);
        bus_b.frame_tick = 1'b0;
        bus_b.collision_detect = 1'b0;
        chk(B + ID_STATE, int'(OVER), "b_collision_beats_win");
        chk(B + ID_SCORE, 2, "b_score_incremented_on_over");
        chk(B + ID_HIGH, 2, "b_high_score");
        ticks(3);
        bus_b.button_in = 1'b1;
        ticks(4);
        chk(B + ID_STATE, int'(IDLE), "b_no_hold_restart");
        bus_b.button_in = 1'b0;
        ticks(4);
        bus_b.button_in = 1'b1;
        ticks(4);
        chk(B + ID_STATE, int'(RUN), "b_second_start");
        bus_b.button_in = 1'b0;
        bus_b.frame_tick = 1'b1;
        ticks(2);
        bus_b.frame_tick = 1'b0;
        chk(B + ID_STATE, int'(WIN), "b_win");
        chk(B + ID_SCORE, 2, "b_win_score");
        chk(B + ID_RUN, 0, "b_win_run_en");
        chk(B + ID_GRCNT, 2, "b_game_reset_pulses");

        // Button held 10 cycles: one pulse, RUN on the 4th cycle after the rise.
        bus_a.button_in = 1'b1;
        ticks(3);
        chk(ID_STATE, int'(IDLE), "t1_idle_before_pulse");
        ticks(1);
        chk(ID_STATE, int'(RUN), "t1_run");
        chk(ID_GR, 1, "t1_game_reset_high");
        chk(ID_RUN, 1, "t1_run_en");
        chk(ID_SCORE, 0, "t1_score_zero");
        ticks(1);
        chk(ID_GR, 0, "t1_game_reset_one_cycle");
        ticks(5);
        bus_a.button_in = 1'b0;
        ticks(1);

        // Collision held through the first 16 frames is ignored.
        bus_a.collision_detect = 1'b1;
        frames_a(15);
        bus_a.frame_tick = 1'b1;
        ticks(1);
        bus_a.collision_detect = 1'b0;
        bus_a.frame_tick = 1'b0;
        ticks(1);
        chk(ID_STATE, int'(RUN), "t3_grace_ignores_collision");
        frames_a(74);
        chk(ID_SCORE, 3, "t2_score_after_90");
        frames_a(29);
        chk(ID_SCORE, 3, "t2_tick_cnt_restarted");
        frames_a(1);
        chk(ID_SCORE, 4, "t2_score_after_120");
        bus_a.collision_detect = 1'b1;
        ticks(1);
        bus_a.collision_detect = 1'b0;
        chk(ID_STATE, int'(OVER), "t3_over");
        chk(ID_HIGH, 4, "t3_high_score");
        chk(ID_SCORE, 4, "t3_score_frozen");
        chk(ID_RUN, 0, "t3_run_en_low");

        // End-screen hold: early press dropped, press after 60 frames accepted.
        frames_a(10);
        bus_a.button_in = 1'b1;
        ticks(6);
        chk(ID_STATE, int'(OVER), "t5_early_press_dropped");
        bus_a.button_in = 1'b0;
        ticks(4);
        frames_a(50);
        bus_a.button_in = 1'b1;
        ticks(4);
        chk(ID_STATE, int'(IDLE), "t5_idle_after_hold");
        chk(ID_SCORE, 4, "t5_score_kept_in_idle");
        bus_a.button_in = 1'b0;
        ticks(4);
        bus_a.button_in = 1'b1;
        ticks(4);
        chk(ID_STATE, int'(RUN), "t5_second_game");
        chk(ID_SCORE, 0, "t5_score_cleared");
        bus_a.button_in = 1'b0;
        frames_a(30);
        chk(ID_SCORE, 1, "t5_second_score");
        bus_a.collision_detect = 1'b1;
        ticks(1);
        bus_a.collision_detect = 1'b0;
        chk(ID_STATE, int'(OVER), "t5_second_over");
        chk(ID_HIGH, 4, "t5_high_score_kept");

        // Reset in the middle of a game.
        frames_a(60);
        bus_a.button_in = 1'b1;
        ticks(4);
        chk(ID_STATE, int'(IDLE), "t6_back_to_idle");
        bus_a.button_in = 1'b0;
        ticks(4);
        bus_a.button_in = 1'b1;
        ticks(4);
        chk(ID_STATE, int'(RUN), "t6_third_game");
        bus_a.button_in = 1'b0;
        frames_a(150);
        chk(ID_SCORE, 5, "t6_score_5");
        chk(ID_HIGH, 4, "t6_high_before_reset");
        reset = 1'b1;
        ticks(1);
        chk(ID_STATE, int'(IDLE), "t6_reset_state");
        chk(ID_SCORE, 0, "t6_reset_score");
        chk(ID_HIGH, 0, "t6_reset_high");
        chk(ID_GR, 0, "t6_reset_game_reset");
        chk(ID_RUN, 0, "t6_reset_run_en");
        reset = 1'b0;
        ticks(2);
        chk(ID_GRCNT, 3, "t6_game_reset_pulses");
        ticks(2);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, 0 required", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
